// File: rtl/intersection_phase_arbiter_if.sv
// Signal bundle between the intersection controller and its environment:
// detector/emergency requests in, per-approach lamp drives and grant status out.
interface intersection_phase_arbiter_if;
    logic [3:0] req;
    logic       emg_req;
    logic [1:0] emg_dir;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic       grant_valid;
    logic [1:0] grant_dir;

    modport master (
        output req, emg_req, emg_dir,
        input  green, yellow, red, grant_valid, grant_dir
    );

    modport slave (
        input  req, emg_req, emg_dir,
        output green, yellow, red, grant_valid, grant_dir
    );
endinterface

// File: rtl/intersection_phase_arbiter.sv
// Round-robin right-of-way scheduler for a four-approach intersection with min/max
// green, yellow and all-red timing. Optional macro EMERGENCY_PREEMPT_EN adds preemption.
module intersection_phase_arbiter #(
    parameter int unsigned TICK_CYCLES  = 100000000,
    parameter int unsigned MIN_GREEN    = 5,
    parameter int unsigned MAX_GREEN    = 15,
    parameter int unsigned YELLOW_TIME  = 3,
    parameter int unsigned ALL_RED_TIME = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    intersection_phase_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ALL_RED = 2'd3
    } state_t;

    localparam logic [31:0] TICK_LAST    = 32'(TICK_CYCLES - 1);
    localparam logic [7:0]  MIN_G        = 8'(MIN_GREEN);
    localparam logic [7:0]  MAX_G        = 8'(MAX_GREEN);
    localparam logic [7:0]  YELLOW_LAST  = 8'(YELLOW_TIME - 1);
    localparam logic [7:0]  ALL_RED_LAST = 8'(ALL_RED_TIME - 1);

    state_t      state_reg;
    logic [1:0]  grant_dir_reg;
    logic [1:0]  last_dir_reg;
    logic [31:0] presc_reg;
    logic [7:0]  timer_reg;

    logic        tick;
    logic [7:0]  elapsed;
    logic [3:0]  rot_req;
    logic [1:0]  rr_off;
    logic [1:0]  rr_dir;
    logic        any_req;
    logic [3:0]  own_onehot;
    logic        own_req;
    logic        compete;
    logic        emg_active;
    logic [1:0]  emg_dir_sel;
    logic        emg_hold;
    logic        emg_preempt;
    logic        arb_valid;
    logic [1:0]  arb_dir;
    logic        green_exit;
    logic        yellow_done;
    logic        all_red_done;

    assign tick = (presc_reg == TICK_LAST);

    // Tick count including the tick landing on this edge, so a green phase ends
    // exactly on the tick edge that completes MIN_GREEN / MAX_GREEN ticks.
    assign elapsed = (tick && (timer_reg != 8'hFF)) ? timer_reg + 8'd1 : timer_reg;

    // Requests rotated so bit 0 is the direction right after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = bus.req[last_dir_reg + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        rr_off = 2'd3;
        if (rot_req[0])      rr_off = 2'd0;
        else if (rot_req[1]) rr_off = 2'd1;
        else if (rot_req[2]) rr_off = 2'd2;
    end

    assign rr_dir     = last_dir_reg + rr_off + 2'd1;
    assign any_req    = |bus.req;
    assign own_onehot = 4'b0001 << grant_dir_reg;
    assign own_req    = |(bus.req & own_onehot);
    assign compete    = |(bus.req & ~own_onehot);

`ifdef EMERGENCY_PREEMPT_EN
    assign emg_active  = bus.emg_req;
    assign emg_dir_sel = bus.emg_dir;
`else
    logic emg_unused;
    assign emg_unused  = ^{bus.emg_req, bus.emg_dir};
    assign emg_active  = 1'b0;
    assign emg_dir_sel = 2'd0;
`endif

    assign emg_hold    = emg_active && (grant_dir_reg == emg_dir_sel);
    assign emg_preempt = emg_active && (grant_dir_reg != emg_dir_sel);
    assign arb_valid   = any_req || emg_active;
    assign arb_dir     = emg_active ? emg_dir_sel : rr_dir;

    assign green_exit   = emg_preempt ||
                          (compete && !emg_hold &&
                           (((elapsed >= MIN_G) && !own_req) || (elapsed >= MAX_G)));
    assign yellow_done  = tick && (timer_reg == YELLOW_LAST);
    assign all_red_done = tick && (timer_reg == ALL_RED_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_dir_reg <= 2'd0;
            last_dir_reg  <= 2'd3;
            presc_reg     <= '0;
            timer_reg     <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 32'd1;
            timer_reg <= elapsed;
            case (state_reg)
                IDLE: begin
                    presc_reg <= '0;
                    timer_reg <= '0;
                    if (arb_valid) begin
                        state_reg     <= GREEN;
                        grant_dir_reg <= arb_dir;
                        last_dir_reg  <= arb_dir;
                    end
                end
                GREEN: begin
                    if (green_exit) begin
                        state_reg <= YELLOW;
                        presc_reg <= '0;
                        timer_reg <= '0;
                    end
                end
                YELLOW: begin
                    if (yellow_done) begin
                        state_reg <= ALL_RED;
                        presc_reg <= '0;
                        timer_reg <= '0;
                    end
                end
                ALL_RED: begin
                    if (all_red_done) begin
                        presc_reg <= '0;
                        timer_reg <= '0;
                        if (arb_valid) begin
                            state_reg     <= GREEN;
                            grant_dir_reg <= arb_dir;
                            last_dir_reg  <= arb_dir;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Lamps decode straight from the state register: one lamp per head, always.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lamp
            logic is_green;
            logic is_yellow;
            assign is_green      = (state_reg == GREEN)  && (grant_dir_reg == 2'(gi));
            assign is_yellow     = (state_reg == YELLOW) && (grant_dir_reg == 2'(gi));
            assign bus.green[gi]  = is_green;
            assign bus.yellow[gi] = is_yellow;
            assign bus.red[gi]    = !(is_green || is_yellow);
        end
    endgenerate

    assign bus.grant_valid = (state_reg == GREEN) || (state_reg == YELLOW);
    assign bus.grant_dir   = grant_dir_reg;
endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Scoreboard bench: expected lamp phases (pattern + duration) are queued with each
// stimulus and compared when the observed lamp pattern changes.
module tb_intersection_phase_arbiter;
    logic clk;
    logic rst_n;

    intersection_phase_arbiter_if bus ();

    intersection_phase_arbiter #(
        .TICK_CYCLES (4),
        .MIN_GREEN   (2),
        .MAX_GREEN   (4),
        .YELLOW_TIME (1),
        .ALL_RED_TIME(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] pat;
        int          len;
    } seg_t;

    seg_t        exp_q[$];
    seg_t        e;
    int          checks;
    int          errors;
    int          extra_cnt;
    int          lamp_bad;
    logic        mon_en;
    logic        seg_armed;
    logic [14:0] seg_pat;
    logic [14:0] cur_pat;
    int          seg_len;
    string       cur_test;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pg(input logic [1:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        return {oh, 4'b0000, ~oh, 1'b1, d};
    endfunction

    function automatic logic [14:0] py(input logic [1:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << d;
        return {4'b0000, oh, ~oh, 1'b1, d};
    endfunction

    function automatic logic [14:0] pr();
        return {4'b0000, 4'b0000, 4'b1111, 1'b0, 2'b00};
    endfunction

    task automatic push_seg(input logic [14:0] p, input int n);
        seg_t s;
        s.pat = p;
        s.len = n;
        exp_q.push_back(s);
    endtask

    // Phase monitor: run-length encodes the lamp pattern on the falling edge.
    always @(negedge clk) begin
        cur_pat = {bus.green, bus.yellow, bus.red, bus.grant_valid,
                   bus.grant_valid ? bus.grant_dir : 2'd0};
        if (rst_n && ((bus.green | bus.yellow | bus.red) != 4'b1111 ||
                      (bus.green & bus.yellow) != 4'b0000 ||
                      (bus.green & bus.red) != 4'b0000 ||
                      (bus.yellow & bus.red) != 4'b0000))
            lamp_bad++;
        if (!rst_n) begin
            seg_len   = 0;
            seg_armed = 1'b0;
            seg_pat   = cur_pat;
        end else if (seg_len != 0 && cur_pat == seg_pat) begin
            seg_len++;
        end else begin
            if (seg_armed && seg_len != 0) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("seg %s pat=%04h len=%0d exp_pat=%04h exp_len=%0d",
                             cur_test, seg_pat, seg_len, e.pat, e.len);
                    check({cur_test, "_pat"}, 32'(seg_pat), 32'(e.pat));
                    check({cur_test, "_len"}, seg_len, e.len);
                end else begin
                    extra_cnt++;
                end
            end
            seg_pat   = cur_pat;
            seg_len   = 1;
            seg_armed = mon_en;
        end
    end

    task automatic do_reset();
        mon_en      = 1'b0;
        bus.req     = 4'b0000;
        bus.emg_req = 1'b0;
        bus.emg_dir = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_sb(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        check({cur_test, "_drain"}, exp_q.size(), 0);
        check({cur_test, "_extra"}, extra_cnt, 0);
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int bad;
        checks      = 0;
        errors      = 0;
        extra_cnt   = 0;
        lamp_bad    = 0;
        mon_en      = 1'b0;
        seg_len     = 0;
        seg_armed   = 1'b0;
        seg_pat     = '0;
        cur_test    = "init";
        rst_n       = 1'b0;
        bus.req     = 4'b0000;
        bus.emg_req = 1'b0;
        bus.emg_dir = 2'd0;

        // Reset state, then async reset in the middle of a yellow phase.
        #1;
        check("rst_red",   32'(bus.red), 32'hF);
        check("rst_green", 32'(bus.green), 32'h0);
        check("rst_gv",    32'(bus.grant_valid), 32'h0);
        do_reset();
        cur_test = "reset";
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0011;
        for (int i = 0; i < 100 && bus.yellow == 4'b0000; i++) @(negedge clk);
        check("reach_yellow", 32'(bus.yellow), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_red",    32'(bus.red), 32'hF);
        check("async_green",  32'(bus.green), 32'h0);
        check("async_yellow", 32'(bus.yellow), 32'h0);
        check("async_gv",     32'(bus.grant_valid), 32'h0);
        check("async_gdir",   32'(bus.grant_dir), 32'h0);
        @(negedge clk);
        bus.req = 4'b0000;
        rst_n   = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.red != 4'b1111 || bus.grant_valid) bad++;
        end
        check("idle_hold", bad, 0);

        // Single request from IDLE: green after one edge, rests with no competitor.
        cur_test = "rest";
        bus.req = 4'b0001;
        @(negedge clk);
        check("first_green", 32'(bus.green), 32'h1);
        check("first_gdir",  32'(bus.grant_dir), 32'h0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.green != 4'b0001) bad++;
        end
        check("rest_green", bad, 0);

        // Max-out against a competitor on direction 2.
        do_reset();
        cur_test = "maxout";
        mon_en = 1'b1;
        push_seg(pg(2'd0), 16);
        push_seg(py(2'd0), 4);
        push_seg(pr(), 4);
        push_seg(pg(2'd2), 16);
        bus.req = 4'b0101;
        wait_sb(300);

        // Gap-out: served request drops while direction 2 waits.
        do_reset();
        cur_test = "gapout";
        mon_en = 1'b1;
        push_seg(pg(2'd0), 8);
        push_seg(py(2'd0), 4);
        push_seg(pr(), 4);
        bus.req = 4'b0001;
        repeat (2) @(negedge clk);
        bus.req = 4'b0100;
        wait_sb(200);
        @(negedge clk);
        check("gapout_next", 32'(bus.green), 32'h4);

        // Fairness: all four requests held.
        do_reset();
        cur_test = "fair";
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_seg(pg(2'(k)), 16);
            push_seg(py(2'(k)), 4);
            push_seg(pr(), 4);
        end
        push_seg(pg(2'd0), 16);
        bus.req = 4'b1111;
        wait_sb(600);

        // Emergency vehicle for direction 3 arrives while direction 1 is green.
        do_reset();
        cur_test = "emg";
        mon_en = 1'b1;
`ifdef EMERGENCY_PREEMPT_EN
        push_seg(pg(2'd1), 1);
        push_seg(py(2'd1), 4);
        push_seg(pr(), 4);
`else
        push_seg(pg(2'd1), 16);
        push_seg(py(2'd1), 4);
        push_seg(pr(), 4);
        push_seg(pg(2'd2), 16);
`endif
        bus.req = 4'b0010;
        @(negedge clk);
        bus.emg_req = 1'b1;
        bus.emg_dir = 2'd3;
        bus.req     = 4'b0111;
        wait_sb(300);
`ifdef EMERGENCY_PREEMPT_EN
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.green != 4'b1000) bad++;
        end
        check("emg_hold", bad, 0);
`endif
        bus.emg_req = 1'b0;

        check("lamp_exclusive", lamp_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
